// File: rtl/unlock_attempt_scheduler.sv
// Round-robin scheduler that feeds password attempts from NREQ requesters into one unlocking
// system, tracks each result, and counts failures. Define UNLOCK_LOCKOUT_EN to enable lockout.
module unlock_attempt_scheduler #(
  parameter int N              = 4,
  parameter int NREQ           = 2,
  parameter int RESP_TIMEOUT   = 64,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 256,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int FCW = $clog2(MAX_FAILS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [N-1:0]      p_data,
  output logic              p_valid,
  input  logic              p_ready,
  input  logic              unlock,
  input  logic              pwd_incorrect,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_ok,
  output logic              rsp_timeout,
  output logic              locked_out,
  output logic [FCW-1:0]    fail_count
);

  localparam int TW = $clog2(RESP_TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StWaitRes,
    StReport,
    StLockout
  } state_e;

  state_e         state_q;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] gnt_id_q;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] ptr_nxt;
  logic [IDW-1:0] cand;
  logic           gnt_found;
  logic           unlock_q;
  logic           pwd_q;
  logic           unlock_edge;
  logic           pwd_edge;
  logic [TW-1:0]  timer_q;
  logic [FCW-1:0] fail_inc;

  // Scan requesters starting at the round-robin pointer; first valid one wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(ptr_q) + k) % NREQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign ptr_nxt = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    req_ready = '0;
    if (state_q == StIdle && gnt_found && !rst) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  // Result inputs are levels; only a fresh rising edge counts as a result.
  assign unlock_edge = unlock & ~unlock_q;
  assign pwd_edge    = pwd_incorrect & ~pwd_q;

  assign fail_inc = (fail_count == FCW'(MAX_FAILS)) ? fail_count : fail_count + 1'b1;

`ifdef UNLOCK_LOCKOUT_EN
  localparam int LCW = $clog2(LOCKOUT_CYCLES + 1);
  logic [LCW-1:0] lock_cnt_q;
  logic           locked_q;
  assign locked_out = locked_q;
`else
  assign locked_out = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      gnt_id_q    <= '0;
      p_data      <= '0;
      p_valid     <= 1'b0;
      unlock_q    <= 1'b0;
      pwd_q       <= 1'b0;
      timer_q     <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_ok      <= 1'b0;
      rsp_timeout <= 1'b0;
      fail_count  <= '0;
`ifdef UNLOCK_LOCKOUT_EN
      lock_cnt_q  <= '0;
      locked_q    <= 1'b0;
`endif
    end else begin
      unlock_q    <= unlock;
      pwd_q       <= pwd_incorrect;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_ok      <= 1'b0;
      rsp_timeout <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (gnt_found) begin
            p_data   <= req_data[int'(gnt_idx) * N +: N];
            gnt_id_q <= gnt_idx;
            ptr_q    <= ptr_nxt;
            p_valid  <= 1'b1;
            state_q  <= StSend;
          end
        end
        StSend: begin
          if (p_ready) begin
            p_valid <= 1'b0;
            timer_q <= '0;
            state_q <= StWaitRes;
          end
        end
        StWaitRes: begin
          if (pwd_edge) begin
            rsp_valid <= 1'b1;
            rsp_id    <= gnt_id_q;
            state_q   <= StReport;
          end else if (unlock_edge) begin
            rsp_valid <= 1'b1;
            rsp_id    <= gnt_id_q;
            rsp_ok    <= 1'b1;
            state_q   <= StReport;
          end else if (timer_q == TW'(RESP_TIMEOUT - 1)) begin
            rsp_valid   <= 1'b1;
            rsp_id      <= gnt_id_q;
            rsp_timeout <= 1'b1;
            state_q     <= StReport;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StReport: begin
          state_q <= StIdle;
          if (rsp_ok) begin
            fail_count <= '0;
          end else begin
            fail_count <= fail_inc;
`ifdef UNLOCK_LOCKOUT_EN
            if (fail_inc == FCW'(MAX_FAILS)) begin
              lock_cnt_q <= '0;
              locked_q   <= 1'b1;
              state_q    <= StLockout;
            end
`endif
          end
        end
`ifdef UNLOCK_LOCKOUT_EN
        StLockout: begin
          if (lock_cnt_q == LCW'(LOCKOUT_CYCLES - 1)) begin
            fail_count <= '0;
            locked_q   <= 1'b0;
            state_q    <= StIdle;
          end else begin
            lock_cnt_q <= lock_cnt_q + 1'b1;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_unlock_attempt_scheduler.sv
// Directed bench for unlock_attempt_scheduler with default parameters; lockout checks follow
// UNLOCK_LOCKOUT_EN.
module tb_unlock_attempt_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [7:0] req_data;
  logic [1:0] req_ready;
  logic [3:0] p_data;
  logic       p_valid;
  logic       p_ready;
  logic       unlock;
  logic       pwd_incorrect;
  logic       rsp_valid;
  logic [0:0] rsp_id;
  logic       rsp_ok;
  logic       rsp_timeout;
  logic       locked_out;
  logic [1:0] fail_count;

  int n_vec = 0;
  int n_err = 0;
  int n;
  int bad_rdy;

  unlock_attempt_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .p_data       (p_data),
    .p_valid      (p_valid),
    .p_ready      (p_ready),
    .unlock       (unlock),
    .pwd_incorrect(pwd_incorrect),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_ok       (rsp_ok),
    .rsp_timeout  (rsp_timeout),
    .locked_out   (locked_out),
    .fail_count   (fail_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Grant, hold one cycle in SEND, then handshake; returns on the first WAIT_RES cycle.
  task automatic attempt(input logic [1:0] rv, input logic [7:0] rd, input logic [1:0] exp_rdy,
                         input logic [3:0] exp_pd);
    req_valid = rv;
    req_data  = rd;
    #1;
    check("grant", 32'(req_ready), 32'(exp_rdy));
    tick();
    check("p_valid_high", 32'(p_valid), 32'd1);
    check("p_data", 32'(p_data), 32'(exp_pd));
    check("ready_after_grant", 32'(req_ready), 32'd0);
    p_ready = 1'b1;
    tick();
    p_ready = 1'b0;
    check("p_valid_drop", 32'(p_valid), 32'd0);
  endtask

  task automatic report(input logic id, input logic ok, input logic to, input logic [1:0] exp_fc);
    tick();
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_id", 32'(rsp_id), 32'(id));
    check("rsp_ok", 32'(rsp_ok), 32'(ok));
    check("rsp_timeout", 32'(rsp_timeout), 32'(to));
    tick();
    check("rsp_pulse_end", 32'(rsp_valid), 32'd0);
    check("fail_count", 32'(fail_count), 32'(exp_fc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    p_ready = 1'b0;
    unlock = 1'b0;
    pwd_incorrect = 1'b0;
    tick();
    tick();
    check("rst_p_valid", 32'(p_valid), 32'd0);
    check("rst_p_data", 32'(p_data), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_locked_out", 32'(locked_out), 32'd0);
    check("rst_fail_count", 32'(fail_count), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    tick();

    // Single attempt, p_ready two cycles after p_valid, unlock 12 cycles into WAIT_RES.
    req_valid = 2'b01;
    req_data  = 8'h0D;
    #1;
    check("t1_grant", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b00;
    check("t1_p_valid", 32'(p_valid), 32'd1);
    check("t1_p_data", 32'(p_data), 32'hD);
    tick();
    check("t1_p_valid_hold", 32'(p_valid), 32'd1);
    check("t1_p_data_hold", 32'(p_data), 32'hD);
    p_ready = 1'b1;
    tick();
    p_ready = 1'b0;
    check("t1_p_valid_drop", 32'(p_valid), 32'd0);
    repeat (11) begin
      tick();
      check("t1_no_rsp", 32'(rsp_valid), 32'd0);
    end
    unlock = 1'b1;
    report(1'b0, 1'b1, 1'b0, 2'd0);

    // Stale unlock level held through the next attempt; only the pwd_incorrect edge counts.
    attempt(2'b10, 8'h60, 2'b10, 4'h6);
    req_valid = 2'b00;
    repeat (3) begin
      tick();
      check("stale_no_rsp", 32'(rsp_valid), 32'd0);
    end
    pwd_incorrect = 1'b1;
    report(1'b1, 1'b0, 1'b0, 2'd1);
    pwd_incorrect = 1'b0;
    unlock = 1'b0;

    // Simultaneous edges: failure wins.
    attempt(2'b01, 8'h0C, 2'b01, 4'hC);
    req_valid = 2'b00;
    unlock = 1'b1;
    pwd_incorrect = 1'b1;
    report(1'b0, 1'b0, 1'b0, 2'd2);
    unlock = 1'b0;
    pwd_incorrect = 1'b0;

    // Success clears the fail counter.
    attempt(2'b10, 8'h90, 2'b10, 4'h9);
    req_valid = 2'b00;
    unlock = 1'b1;
    report(1'b1, 1'b1, 1'b0, 2'd0);
    unlock = 1'b0;

    // Round robin with both requesters pending, every attempt fails.
    attempt(2'b11, 8'h0A, 2'b01, 4'hA);
    pwd_incorrect = 1'b1;
    report(1'b0, 1'b0, 1'b0, 2'd1);
    pwd_incorrect = 1'b0;
    attempt(2'b11, 8'h0A, 2'b10, 4'h0);
    pwd_incorrect = 1'b1;
    report(1'b1, 1'b0, 1'b0, 2'd2);
    pwd_incorrect = 1'b0;
    attempt(2'b11, 8'h0A, 2'b01, 4'hA);
    pwd_incorrect = 1'b1;
    report(1'b0, 1'b0, 1'b0, 2'd3);
    pwd_incorrect = 1'b0;

`ifdef UNLOCK_LOCKOUT_EN
    n = 0;
    bad_rdy = 0;
    while (locked_out === 1'b1 && n < 400) begin
      if (req_ready !== 2'b00) bad_rdy++;
      n++;
      tick();
    end
    check("lockout_cycles", 32'(n), 32'd256);
    check("lockout_no_ready", 32'(bad_rdy), 32'd0);
    check("lockout_fc_cleared", 32'(fail_count), 32'd0);
    check("lockout_resume_grant", 32'(req_ready), 32'b10);
    req_valid = 2'b00;
`else
    check("no_lockout", 32'(locked_out), 32'd0);
    check("no_lockout_grant", 32'(req_ready), 32'b10);
    attempt(2'b11, 8'h0A, 2'b10, 4'h0);
    pwd_incorrect = 1'b1;
    report(1'b1, 1'b0, 1'b0, 2'd3);
    pwd_incorrect = 1'b0;
    check("sat_no_lockout", 32'(locked_out), 32'd0);
    req_valid = 2'b00;
`endif

    // Clear the counter before the timeout attempt.
    attempt(2'b01, 8'h03, 2'b01, 4'h3);
    req_valid = 2'b00;
    unlock = 1'b1;
    report(1'b0, 1'b1, 1'b0, 2'd0);
    unlock = 1'b0;

    // Timeout: no result edge, response 64 cycles after WAIT_RES entry.
    attempt(2'b10, 8'h50, 2'b10, 4'h5);
    req_valid = 2'b00;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("timeout_latency", 32'(n), 32'd64);
    check("timeout_rsp_id", 32'(rsp_id), 32'd1);
    check("timeout_rsp_ok", 32'(rsp_ok), 32'd0);
    check("timeout_flag", 32'(rsp_timeout), 32'd1);
    tick();
    check("timeout_pulse_end", 32'(rsp_valid), 32'd0);
    check("timeout_fail_count", 32'(fail_count), 32'd1);

    // Reset during SEND; pointer must restart at requester 0.
    req_valid = 2'b01;
    req_data  = 8'h17;
    #1;
    check("rst_mid_grant", 32'(req_ready), 32'd1);
    tick();
    check("rst_mid_send", 32'(p_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_p_valid", 32'(p_valid), 32'd0);
    check("rst_async_p_data", 32'(p_data), 32'd0);
    check("rst_async_rsp", 32'(rsp_valid), 32'd0);
    check("rst_async_ready", 32'(req_ready), 32'd0);
    check("rst_async_fc", 32'(fail_count), 32'd0);
    check("rst_async_locked", 32'(locked_out), 32'd0);
    req_valid = 2'b11;
    tick();
    check("rst_hold_rsp", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_ptr_zero", 32'(req_ready), 32'b01);
    tick();
    req_valid = 2'b00;
    check("post_rst_p_valid", 32'(p_valid), 32'd1);
    check("post_rst_p_data", 32'(p_data), 32'h7);
    check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
